// File: rtl/ls_chip_bit_tx_if.sv
// Bundle for the landscape-sampling bit transmitter: request/word in, 3-wire serial link and status out.
// master = the side that issues requests and watches the link; slave = the transmitter.
interface ls_chip_bit_tx_if #(
  parameter int unsigned bit_chip = 6,
  parameter int unsigned bit_fifo = 2
);
  logic                request_z;
  logic [bit_chip-1:0] bit_to_chip;
  logic                sclk;
  logic                sdata;
  logic                s_frame;
  logic                busy;
  logic                ovf;
  logic [bit_fifo:0]   fifo_level;

  modport master (
    output request_z, bit_to_chip,
    input  sclk, sdata, s_frame, busy, ovf, fifo_level
  );

  modport slave (
    input  request_z, bit_to_chip,
    output sclk, sdata, s_frame, busy, ovf, fifo_level
  );
endinterface

// File: rtl/ls_chip_bit_tx.sv
// Captures a word after each chip request_z edge, buffers it and ships it MSB first over sclk/sdata/s_frame.
// Optional macro LS_TX_PARITY_EN appends one even-parity bit after the payload LSB.
module ls_chip_bit_tx #(
  parameter int unsigned bit_chip  = 6,
  parameter int unsigned bit_fifo  = 2,
  parameter int unsigned r_div     = 4,
  parameter int unsigned cap_delay = 4
) (
  input  logic              clk_main,
  input  logic              rst,
  ls_chip_bit_tx_if.slave   tx_if
);

  localparam int unsigned DEPTH = 2**bit_fifo;
`ifdef LS_TX_PARITY_EN
  localparam int unsigned N = bit_chip + 1;
`else
  localparam int unsigned N = bit_chip;
`endif
  localparam int unsigned BW  = $clog2(N);
  localparam int unsigned DW  = (r_div > 1) ? $clog2(r_div) : 1;
  localparam int unsigned CW  = (cap_delay > 1) ? $clog2(cap_delay) : 1;
  localparam int unsigned LW  = bit_fifo + 1;
  localparam int unsigned PW  = bit_fifo;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_e;

  logic                req_s1_q, req_s2_q, req_s3_q;
  logic                cap_pend_q;
  logic [CW-1:0]       cap_cnt_q;
  logic                ovf_q;
  logic [bit_chip-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  state_e              state_q;
  logic [N-2:0]        shift_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [DW-1:0]       div_cnt_q;
  logic                sclk_q, sdata_q, s_frame_q, busy_q;

  logic                edge_c, push_c, full_c, wr_en_c, pop_c;
  logic [N-1:0]        load_word_c;

  assign edge_c  = req_s2_q & ~req_s3_q;
  assign push_c  = cap_pend_q && (cap_cnt_q == '0);
  assign full_c  = (level_q == LW'(DEPTH));
  assign wr_en_c = push_c & ~full_c;
  assign pop_c   = (state_q == LOAD);

`ifdef LS_TX_PARITY_EN
  assign load_word_c = {mem_q[rd_ptr_q], ^mem_q[rd_ptr_q]};
`else
  assign load_word_c = mem_q[rd_ptr_q];
`endif

  // Request synchroniser, capture delay and sticky overflow
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      req_s1_q   <= 1'b0;
      req_s2_q   <= 1'b0;
      req_s3_q   <= 1'b0;
      cap_pend_q <= 1'b0;
      cap_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      req_s1_q <= tx_if.request_z;
      req_s2_q <= req_s1_q;
      req_s3_q <= req_s2_q;
      if (cap_pend_q) begin
        if (cap_cnt_q == '0) cap_pend_q <= 1'b0;
        else                 cap_cnt_q  <= cap_cnt_q - CW'(1);
      end else if (edge_c) begin
        cap_pend_q <= 1'b1;
        cap_cnt_q  <= CW'(cap_delay - 1);
      end
      if ((edge_c && cap_pend_q) || (push_c && full_c)) ovf_q <= 1'b1;
    end
  end

  // FIFO pointers and level; a full FIFO drops the incoming word
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_main) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= tx_if.bit_to_chip;
  end

  // Serialiser FSM; MSB goes straight to sdata on load, shift_q holds the remaining bits
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      s_frame_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            state_q   <= LOAD;
            s_frame_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          shift_q   <= load_word_c[N-2:0];
          sdata_q   <= load_word_c[N-1];
          bit_cnt_q <= '0;
          div_cnt_q <= DW'(r_div - 1);
          state_q   <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (div_cnt_q == '0) begin
            state_q   <= SHIFT_HI;
            sclk_q    <= 1'b1;
            div_cnt_q <= DW'(r_div - 1);
          end else begin
            div_cnt_q <= div_cnt_q - DW'(1);
          end
        end
        SHIFT_HI: begin
          if (div_cnt_q == '0) begin
            sclk_q    <= 1'b0;
            div_cnt_q <= DW'(r_div - 1);
            if (bit_cnt_q == BW'(N - 1)) begin
              state_q <= DONE;
              sdata_q <= 1'b0;
            end else begin
              state_q   <= SHIFT_LO;
              sdata_q   <= shift_q[N-2];
              shift_q   <= {shift_q[N-3:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end else begin
            div_cnt_q <= div_cnt_q - DW'(1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          s_frame_q <= 1'b0;
          busy_q    <= 1'b0;
          sdata_q   <= 1'b0;
          sclk_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_if.sclk       = sclk_q;
  assign tx_if.sdata      = sdata_q;
  assign tx_if.s_frame    = s_frame_q;
  assign tx_if.busy       = busy_q;
  assign tx_if.ovf        = ovf_q;
  assign tx_if.fifo_level = level_q;

endmodule

// File: tb/tb_ls_chip_bit_tx.sv
// Directed bench for ls_chip_bit_tx: one DUT at r_div=4, one at r_div=1.
module tb_ls_chip_bit_tx;
  localparam int unsigned BC = 6;
  localparam int unsigned BF = 2;
`ifdef LS_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = BC + PAR;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ls_chip_bit_tx_if #(.bit_chip(BC), .bit_fifo(BF)) if0 ();
  ls_chip_bit_tx_if #(.bit_chip(BC), .bit_fifo(BF)) if1 ();

  ls_chip_bit_tx #(.bit_chip(BC), .bit_fifo(BF), .r_div(4), .cap_delay(4)) u_dut0 (
    .clk_main(clk), .rst(rst), .tx_if(if0));
  ls_chip_bit_tx #(.bit_chip(BC), .bit_fifo(BF), .r_div(1), .cap_delay(4)) u_dut1 (
    .clk_main(clk), .rst(rst), .tx_if(if1));

  function automatic logic [15:0] exp_bits(input logic [5:0] w);
    if (PAR != 0) exp_bits = {9'b0, w, ^w};
    else          exp_bits = {10'b0, w};
  endfunction

  function automatic logic sf(input int sel);
    sf = (sel != 0) ? if1.s_frame : if0.s_frame;
  endfunction
  function automatic logic sc(input int sel);
    sc = (sel != 0) ? if1.sclk : if0.sclk;
  endfunction
  function automatic logic sd(input int sel);
    sd = (sel != 0) ? if1.sdata : if0.sdata;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One-cycle request_z pulse starting now (#1 after an edge)
  task automatic pulse(input int sel);
    if (sel != 0) if1.request_z = 1'b1; else if0.request_z = 1'b1;
    step(1);
    if (sel != 0) if1.request_z = 1'b0; else if0.request_z = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  // Waits for s_frame, records sdata at each sclk rise, frame length and sclk period
  task automatic wait_frame(input int sel, output logic [15:0] bits, output int nb,
                            output int flen, output int per, output int t);
    int   last;
    logic prev;
    bits = '0; nb = 0; flen = 0; per = 0; t = 0; last = 0; prev = 1'b0;
    while (!sf(sel) && t < 2000) begin step(1); t++; end
    if (!sf(sel)) begin
      checks++; errors++;
      $display("FAIL frame_start timeout sel=%0d", sel);
      return;
    end
    while (sf(sel) && flen < 1000) begin
      if (sc(sel) && !prev) begin
        bits = {bits[14:0], sd(sel)};
        nb++;
        if (nb > 1) per = flen - last;
        last = flen;
      end
      prev = sc(sel);
      flen++;
      step(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++; if (if0.sclk !== 1'b0)    begin errors++; $display("FAIL rst_sclk got %b want 0", if0.sclk); end
    checks++; if (if0.sdata !== 1'b0)   begin errors++; $display("FAIL rst_sdata got %b want 0", if0.sdata); end
    checks++; if (if0.s_frame !== 1'b0) begin errors++; $display("FAIL rst_s_frame got %b want 0", if0.s_frame); end
    checks++; if (if0.busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", if0.busy); end
    checks++; if (if0.ovf !== 1'b0)     begin errors++; $display("FAIL rst_ovf got %b want 0", if0.ovf); end
    checks++; if (if0.fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", if0.fifo_level); end
    rst = 1'b0;
    step(3);
    checks++; if (if0.busy !== 1'b0 || if1.busy !== 1'b0) begin
      errors++; $display("FAIL post_rst_busy got %b/%b want 0/0", if0.busy, if1.busy); end
  endtask

  task automatic test_single();
    logic [15:0] bits; int nb, flen, per, t;
    do_reset();
    if0.bit_to_chip = 6'b101101;
    pulse(0);
    step(5);
    checks++; if (if0.fifo_level !== 3'd0) begin errors++; $display("FAIL single_push_early level %0d want 0", if0.fifo_level); end
    step(1);
    checks++; if (if0.fifo_level !== 3'd1) begin errors++; $display("FAIL single_push_at_7 level %0d want 1", if0.fifo_level); end
    wait_frame(0, bits, nb, flen, per, t);
    checks++; if (t !== 1) begin errors++; $display("FAIL single_load_latency got %0d want 1", t); end
    checks++; if (nb !== NB) begin errors++; $display("FAIL single_nbits got %0d want %0d", nb, NB); end
    checks++; if (bits !== exp_bits(6'b101101)) begin errors++; $display("FAIL single_bits got %h want %h", bits, exp_bits(6'b101101)); end
    checks++; if (flen !== 8*NB+2) begin errors++; $display("FAIL single_frame_len got %0d want %0d", flen, 8*NB+2); end
    checks++; if (per !== 8) begin errors++; $display("FAIL single_sclk_period got %0d want 8", per); end
    checks++; if (if0.busy !== 1'b0 || if0.fifo_level !== 3'd0) begin
      errors++; $display("FAIL single_after busy %b level %0d want 0 0", if0.busy, if0.fifo_level); end
  endtask

  task automatic test_cap_pending();
    logic [15:0] bits; int nb, flen, per, t, hi;
    do_reset();
    if0.bit_to_chip = 6'b110010;
    pulse(0);
    step(1);
    pulse(0);
    step(1);
    checks++; if (if0.ovf !== 1'b0) begin errors++; $display("FAIL pend_ovf_early got %b want 0", if0.ovf); end
    step(1);
    checks++; if (if0.ovf !== 1'b1) begin errors++; $display("FAIL pend_ovf got %b want 1", if0.ovf); end
    wait_frame(0, bits, nb, flen, per, t);
    checks++; if (bits !== exp_bits(6'b110010) || nb !== NB) begin
      errors++; $display("FAIL pend_frame bits %h n %0d want %h n %0d", bits, nb, exp_bits(6'b110010), NB); end
    hi = 0;
    for (int i = 0; i < 100; i++) begin if (if0.s_frame) hi++; step(1); end
    checks++; if (hi !== 0) begin errors++; $display("FAIL pend_second_frame high_cycles %0d want 0", hi); end
    checks++; if (if0.ovf !== 1'b1) begin errors++; $display("FAIL pend_ovf_sticky got %b want 1", if0.ovf); end
  endtask

  task automatic test_overflow();
    logic [5:0] words [6];
    int lvl_exp [6];
    logic [15:0] bits; int nb, flen, per, t, hi;
    words   = '{6'h2A, 6'h15, 6'h33, 6'h0F, 6'h38, 6'h07};
    lvl_exp = '{1, 1, 2, 3, 4, 4};
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if0.bit_to_chip = words[i];
          pulse(0);
          step(6);
          checks++; if (if0.fifo_level !== 3'(lvl_exp[i])) begin
            errors++; $display("FAIL ovf_level[%0d] got %0d want %0d", i, if0.fifo_level, lvl_exp[i]); end
          checks++; if (if0.ovf !== (i == 5)) begin
            errors++; $display("FAIL ovf_flag[%0d] got %b want %b", i, if0.ovf, (i == 5)); end
          step(3);
        end
      end
      begin
        for (int k = 0; k < 5; k++) begin
          wait_frame(0, bits, nb, flen, per, t);
          checks++; if (bits !== exp_bits(words[k]) || nb !== NB) begin
            errors++; $display("FAIL ovf_frame[%0d] bits %h n %0d want %h n %0d", k, bits, nb, exp_bits(words[k]), NB); end
        end
      end
    join
    hi = 0;
    for (int i = 0; i < 120; i++) begin if (if0.s_frame) hi++; step(1); end
    checks++; if (hi !== 0) begin errors++; $display("FAIL ovf_sixth_frame high_cycles %0d want 0", hi); end
    checks++; if (if0.ovf !== 1'b1 || if0.fifo_level !== 3'd0) begin
      errors++; $display("FAIL ovf_final ovf %b level %0d want 1 0", if0.ovf, if0.fifo_level); end
  endtask

  task automatic test_mid_frame_reset();
    int rises, n, bad;
    logic prev;
    do_reset();
    if0.bit_to_chip = 6'b011010;
    pulse(0);
    step(8);
    pulse(0);
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 4 && n < 500) begin
      if (if0.sclk && !prev) rises++;
      prev = if0.sclk;
      if (rises < 4) begin step(1); n++; end
    end
    checks++; if (rises !== 4) begin errors++; $display("FAIL midrst_find_bit3 rises %0d want 4", rises); end
    checks++; if (if0.fifo_level !== 3'd1) begin errors++; $display("FAIL midrst_pre_level got %0d want 1", if0.fifo_level); end
    #3 rst = 1'b1;
    #1;
    checks++; if (if0.sclk !== 1'b0 || if0.sdata !== 1'b0 || if0.s_frame !== 1'b0) begin
      errors++; $display("FAIL midrst_link sclk %b sdata %b frame %b want 0 0 0", if0.sclk, if0.sdata, if0.s_frame); end
    checks++; if (if0.busy !== 1'b0 || if0.ovf !== 1'b0 || if0.fifo_level !== 3'd0) begin
      errors++; $display("FAIL midrst_status busy %b ovf %b level %0d want 0 0 0", if0.busy, if0.ovf, if0.fifo_level); end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      if (if0.sclk || if0.s_frame || if0.fifo_level != 3'd0) bad++;
      step(1);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_after_release active_cycles %0d want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int nb, flen, per, t;
    do_reset();
    if1.bit_to_chip = 6'h3F;
    pulse(1);
    step(4);
    pulse(1);
    step(1);
    if1.bit_to_chip = 6'h00;
    wait_frame(1, bits, nb, flen, per, t);
    checks++; if (bits !== exp_bits(6'h3F) || nb !== NB) begin
      errors++; $display("FAIL b2b_frame1 bits %h n %0d want %h n %0d", bits, nb, exp_bits(6'h3F), NB); end
    checks++; if (flen !== 2*NB+2) begin errors++; $display("FAIL b2b_frame1_len got %0d want %0d", flen, 2*NB+2); end
    checks++; if (per !== 2) begin errors++; $display("FAIL b2b_sclk_period got %0d want 2", per); end
    wait_frame(1, bits, nb, flen, per, t);
    checks++; if (t !== 1) begin errors++; $display("FAIL b2b_gap got %0d want 1", t); end
    checks++; if (bits !== exp_bits(6'h00) || nb !== NB) begin
      errors++; $display("FAIL b2b_frame2 bits %h n %0d want %h n %0d", bits, nb, exp_bits(6'h00), NB); end
    checks++; if (flen !== 2*NB+2) begin errors++; $display("FAIL b2b_frame2_len got %0d want %0d", flen, 2*NB+2); end
  endtask

`ifdef LS_TX_PARITY_EN
  task automatic test_parity();
    logic [15:0] bits; int nb, flen, per, t;
    do_reset();
    if0.bit_to_chip = 6'b000111;
    pulse(0);
    wait_frame(0, bits, nb, flen, per, t);
    checks++; if (nb !== 7 || bits !== 16'b0000000000001111) begin
      errors++; $display("FAIL parity_bits got %h n %0d want 000f n 7", bits, nb); end
    checks++; if (flen !== 58) begin errors++; $display("FAIL parity_frame_len got %0d want 58", flen); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    if0.request_z = 1'b0; if0.bit_to_chip = '0;
    if1.request_z = 1'b0; if1.bit_to_chip = '0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_cap_pending();
    test_overflow();
    test_mid_frame_reset();
    test_back_to_back();
`ifdef LS_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
